// File: rtl/histo_pkg.sv
// rtl/histo_pkg.sv - shared histogram readout types and default sizes
package histo_pkg;

  localparam int HRS_NCH    = 64;
  localparam int HRS_NWORDS = 8;
  localparam int HRS_WIDTH  = 32;

  localparam logic [7:0] HRS_HDR_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE_WAIT,
    XFER,
    CLEAR,
    NEXT
  } hrs_state_t;

endpackage

// File: rtl/hrs_snapshot_buf.sv
// rtl/hrs_snapshot_buf.sv - NWORDS x WIDTH histogram capture register with word read mux
module hrs_snapshot_buf
  import histo_pkg::*;
#(
  parameter int NWORDS = HRS_NWORDS,
  parameter int WIDTH  = HRS_WIDTH,
  parameter int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic [NWORDS*WIDTH-1:0] din,
  input  logic [IW-1:0]           rd_idx,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] mem [NWORDS];

  // Contents are don't-care until the first load, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NWORDS; k++) begin
        mem[k] <= din[k*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/histo_readout_seq.sv
// rtl/histo_readout_seq.sv - steps histostosend over a channel range and streams snapshots
// Optional per-channel header word: define HRS_HEADER_EN.
module histo_readout_seq
  import histo_pkg::*;
#(
  parameter int NCH    = HRS_NCH,
  parameter int NWORDS = HRS_NWORDS,
  parameter int WIDTH  = HRS_WIDTH,
  parameter int SETTLE = 3
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [7:0]              first_ch,
  input  logic [7:0]              last_ch,
  input  logic                    clear_after,
  input  logic                    abort,
  output logic [7:0]              hist_sel,
  output logic                    hist_reset,
  input  logic [NWORDS*WIDTH-1:0] hist_data,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_range
);

`ifdef HRS_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NW_CH = NWORDS + HDR;
  localparam int IW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WW    = $clog2(NW_CH + 1);
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WW-1:0] W_LAST   = WW'(NW_CH - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
  localparam logic [8:0]    NCH9     = 9'(NCH);

  hrs_state_t        state;
  logic [7:0]        ch;
  logic [7:0]        last_q;
  logic              clr_q;
  logic [CW-1:0]     cnt;
  logic [WW-1:0]     w;
  logic [WW-1:0]     sel_idx;
  logic [IW-1:0]     rd_idx;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  nxt_word;
  logic              snap_load;

`ifdef HRS_HEADER_EN
  logic [15:0]       seq_cnt;
  logic [15:0]       seq_cur;
`endif

  assign busy      = (state != IDLE);
  assign snap_load = (state == SETTLE_WAIT) && (cnt == '0);

  hrs_snapshot_buf #(
    .NWORDS (NWORDS),
    .WIDTH  (WIDTH),
    .IW     (IW)
  ) u_buf (
    .clk     (clk),
    .load    (snap_load),
    .din     (hist_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Look one word ahead on a handshake so the stream runs at one word per cycle.
  always_comb begin
    sel_idx  = (out_valid && out_ready) ? (w + WW'(1)) : w;
    rd_idx   = IW'(sel_idx - WW'(HDR));
    nxt_word = rd_data;
`ifdef HRS_HEADER_EN
    if (sel_idx == '0) begin
      nxt_word = WIDTH'({HRS_HDR_MAGIC, ch, seq_cur});
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      ch         <= '0;
      last_q     <= '0;
      clr_q      <= 1'b0;
      cnt        <= '0;
      w          <= '0;
      hist_sel   <= '0;
      hist_reset <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      err_range  <= 1'b0;
`ifdef HRS_HEADER_EN
      seq_cnt    <= '0;
      seq_cur    <= '0;
`endif
    end else begin
      done      <= 1'b0;
      err_range <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        out_valid  <= 1'b0;
        out_last   <= 1'b0;
        hist_reset <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              if (first_ch > last_ch || {1'b0, last_ch} >= NCH9) begin
                err_range <= 1'b1;
              end else begin
                ch     <= first_ch;
                last_q <= last_ch;
                clr_q  <= clear_after;
                state  <= SELECT;
`ifdef HRS_HEADER_EN
                seq_cur <= seq_cnt;
                seq_cnt <= seq_cnt + 16'd1;
`endif
              end
            end
          end
          SELECT: begin
            hist_sel <= ch;
            cnt      <= CNT_INIT;
            state    <= SETTLE_WAIT;
          end
          SETTLE_WAIT: begin
            if (cnt == '0) begin
              w     <= '0;
              state <= XFER;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          XFER: begin
            if (!out_valid || out_ready) begin
              if (out_valid && w == W_LAST) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (clr_q) begin
                  hist_reset <= 1'b1;
                  state      <= CLEAR;
                end else begin
                  state <= NEXT;
                end
              end else begin
                out_valid <= 1'b1;
                out_data  <= nxt_word;
                out_last  <= (sel_idx == W_LAST) && (ch == last_q);
                if (out_valid) begin
                  w <= w + WW'(1);
                end
              end
            end
          end
          CLEAR: begin
            hist_reset <= 1'b0;
            state      <= NEXT;
          end
          NEXT: begin
            if (ch == last_q) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              ch    <= ch + 8'd1;
              state <= SELECT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_histo_readout_seq.sv
// tb/tb_histo_readout_seq.sv - self-checking bench for histo_readout_seq
module tb_histo_readout_seq;

  localparam int NCH    = 64;
  localparam int NWORDS = 8;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 3;
`ifdef HRS_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NW_CH = NWORDS + HDR;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic                    start;
  logic [7:0]              first_ch;
  logic [7:0]              last_ch;
  logic                    clear_after;
  logic                    abort;
  logic [7:0]              hist_sel;
  logic                    hist_reset;
  logic [NWORDS*WIDTH-1:0] hist_data;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic                    err_range;

  always #5 clk = ~clk;

  histo_readout_seq #(
    .NCH    (NCH),
    .NWORDS (NWORDS),
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .first_ch    (first_ch),
    .last_ch     (last_ch),
    .clear_after (clear_after),
    .abort       (abort),
    .hist_sel    (hist_sel),
    .hist_reset  (hist_reset),
    .hist_data   (hist_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err_range   (err_range)
  );

  // Trigger core stand-in: two register stages from histostosend to histosout.
  logic [7:0]  sel_d1, sel_d2;
  logic [31:0] bias;
  always @(posedge clk) begin
    sel_d1 <= hist_sel;
    sel_d2 <= sel_d1;
  end

  function automatic logic [NWORDS*WIDTH-1:0] core_words(input logic [7:0] s, input logic [31:0] b);
    logic [NWORDS*WIDTH-1:0] v;
    for (int k = 0; k < NWORDS; k++) v[k*WIDTH +: WIDTH] = {24'd0, s} * 32'd16 + 32'(k) + b;
    return v;
  endfunction

  assign hist_data = core_words(sel_d2, bias);

  logic rdy_rand;
  logic rnd_bit = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end
  assign out_ready = rdy_rand ? rnd_bit : 1'b1;

  // Monitor samples on the falling edge, where everything is stable until the next rising edge.
  logic [32:0] got_q[$];
  logic [7:0]  rst_q[$];
  int n_done = 0, n_err = 0, n_valid = 0, n_busy = 0, stab_errs = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    if (hist_reset) rst_q.push_back(hist_sel);
    if (done) n_done++;
    if (err_range) n_err++;
    if (done && err_range) stab_errs++;
    if (out_valid) n_valid++;
    if (busy) n_busy++;
    if (prev_stall && nrst && !(out_valid && {out_last, out_data} == prev_word)) stab_errs++;
    prev_stall = nrst && !abort && out_valid && !out_ready;
    prev_word  = {out_last, out_data};
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_seq = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference stream: every channel in range, optional header, then NWORDS words.
  task automatic build_exp(input logic [7:0] f, input logic [7:0] l, input int seq,
                           input logic [31:0] b, output logic [32:0] q[$]);
    q = {};
    for (int c = f; c <= l; c++) begin
      if (HDR != 0) q.push_back({1'b0, 8'hA5, 8'(c), 16'(seq)});
      for (int k = 0; k < NWORDS; k++)
        q.push_back({(c == l) && (k == NWORDS - 1), 32'(c) * 32'd16 + 32'(k) + b});
    end
  endtask

  task automatic run_range(input logic [7:0] f, input logic [7:0] l, input logic clr,
                           input logic rnd, input logic exp_err, input logic [31:0] b);
    int bw, br, d0, e0, v0, u0, s0;
    bit fin;
    logic [32:0] eq[$];
    bias = b;
    rdy_rand = rnd;
    bw = got_q.size(); br = rst_q.size();
    d0 = n_done; e0 = n_err; v0 = n_valid; u0 = n_busy; s0 = stab_errs;
    first_ch = f; last_ch = l; clear_after = clr; start = 1'b1;
    tick();
    start = 1'b0;
    fin = 0;
    for (int i = 0; i < 6000; i++) begin
      if (n_done != d0 || n_err != e0) begin
        fin = 1;
        break;
      end
      tick();
    end
    repeat (3) tick();
    check("run finished", 64'(fin), 64'd1);
    if (exp_err) begin
      check("err_range pulses", 64'(n_err - e0), 64'd1);
      check("done on error", 64'(n_done - d0), 64'd0);
      check("valid on error", 64'(n_valid - v0), 64'd0);
      check("busy on error", 64'(n_busy - u0), 64'd0);
    end else begin
      build_exp(f, l, exp_seq, b, eq);
      exp_seq++;
      check("word count", 64'(got_q.size() - bw), 64'(eq.size()));
      for (int i = 0; i < eq.size() && bw + i < got_q.size(); i++)
        check($sformatf("word[%0d] ch%0d..%0d", i, f, l), 64'(got_q[bw + i]), 64'(eq[i]));
      check("hist_reset pulses", 64'(rst_q.size() - br), clr ? 64'(l - f + 1) : 64'd0);
      for (int i = 0; clr && i <= int'(l - f) && br + i < rst_q.size(); i++)
        check("hist_reset channel", 64'(rst_q[br + i]), 64'(f + 8'(i)));
      check("done pulses", 64'(n_done - d0), 64'd1);
      check("err on good run", 64'(n_err - e0), 64'd0);
      check("stable while stalled", 64'(stab_errs - s0), 64'd0);
    end
  endtask

  typedef struct {
    logic [7:0] first;
    logic [7:0] last;
    logic       clr;
    logic       rnd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bw, d0;
    bit fin;
    logic [32:0] eq[$];

    vecs[0] = '{8'd3,  8'd5,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'd3,  8'd5,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'd3,  8'd5,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'd10, 8'd9,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'd0,  8'd64, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'd2,  8'd2,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'd2,  8'd2,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'd62, 8'd63, 1'b1, 1'b1, 1'b0};

    nrst = 1'b0; start = 1'b0; first_ch = '0; last_ch = '0;
    clear_after = 1'b0; abort = 1'b0; rdy_rand = 1'b0; bias = '0;
    repeat (3) tick();
    check("reset hist_sel", 64'(hist_sel), 64'd0);
    check("reset hist_reset", 64'(hist_reset), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset err_range", 64'(err_range), 64'd0);
    nrst = 1'b1;
    tick();

    // Start and abort together in IDLE: start must be dropped.
    start = 1'b1; abort = 1'b1; first_ch = 8'd1; last_ch = 8'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("start+abort busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++)
      run_range(vecs[i].first, vecs[i].last, vecs[i].clr, vecs[i].rnd, vecs[i].exp_err, 32'd0);

    // Abort while channel 7 word 4 is on the bus; that word still transfers.
    rdy_rand = 1'b0; bias = '0;
    bw = got_q.size(); d0 = n_done;
    first_ch = 8'd6; last_ch = 8'd9; clear_after = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    fin = 0;
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() - bw == NW_CH + HDR + 4) begin
        fin = 1;
        break;
      end
      tick();
    end
    check("abort point reached", 64'(fin), 64'd1);
    check("abort word on bus", 64'(out_data), 64'd116);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("valid after abort", 64'(out_valid), 64'd0);
    check("busy after abort", 64'(busy), 64'd0);
    repeat (20) tick();
    check("done after abort", 64'(n_done - d0), 64'd0);
    check("words before abort", 64'(got_q.size() - bw), 64'(NW_CH + HDR + 5));
    build_exp(8'd6, 8'd9, exp_seq, 32'd0, eq);
    exp_seq++;
    for (int i = 0; i < NW_CH + HDR + 5 && bw + i < got_q.size(); i++)
      check($sformatf("abort word[%0d]", i), 64'({1'b0, got_q[bw + i][31:0]}), 64'({1'b0, eq[i][31:0]}));
    run_range(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Randomised ranges, including out-of-range requests, checked against the range rule.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] f, l;
      f = 8'($urandom_range(0, 66));
      l = (i % 3 == 0) ? 8'($urandom_range(0, 70)) : 8'((f > 60) ? 63 : f + $urandom_range(0, 3));
      run_range(f, l, 1'($urandom_range(0, 1)), 1'b1, (f > l) || (l >= 8'(NCH)), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
